// File: rtl/dac_playback_12bit.sv
`default_nettype none
// ============================================================================
// Module      : dac_playback_12bit
// Description : Replays a buffer of 12-bit samples to an MCP4921-class SPI
//               DAC. One 16-bit write frame {DAC_CFG, sample} per sample,
//               oldest sample first, SPI mode 0, MSB first. The SCLK rate is
//               set by HALF_PER. CS is held high for CS_GAP cycles between
//               frames. A one-cycle done pulse follows the last frame.
// Ports       : clk        - system clock
//               rst        - asynchronous reset, active low
//               start      - one-cycle request, honoured only when idle
//               storage    - sample buffer, sample k at [12k+11:12k]
//               CS         - DAC chip select, active low
//               SCLK       - SPI clock, idle low
//               MOSI       - SPI data, MSB first
//               busy       - high while a buffer is being played
//               done       - one-cycle pulse when the buffer is finished
//               sample_idx - index of the sample being sent
// Revision    : 1.0 - initial release
// ============================================================================
module dac_playback_12bit #(
    parameter int         HALF_PER    = 250,
    parameter int         NUM_SAMPLES = 10,
    parameter int         CS_GAP      = 500,
    parameter logic [3:0] DAC_CFG     = 4'b0011
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [12*NUM_SAMPLES-1:0] storage,
    output logic                      CS,
    output logic                      SCLK,
    output logic                      MOSI,
    output logic                      busy,
    output logic                      done,
    output logic [3:0]                sample_idx
);

    // One shared counter times both the SCLK half periods and the CS gap.
    // It only has to reach the larger of the two limits minus one.
    localparam int c_CNT_MAX = (HALF_PER > CS_GAP) ? HALF_PER : CS_GAP;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(HALF_PER - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(CS_GAP - 1);
    localparam logic [3:0]         c_IDX_FIRST = 4'(NUM_SAMPLES - 1);
    localparam logic [3:0]         c_LAST_BIT  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_BIT_LO = 3'd2,
        S_BIT_HI = 3'd3,
        S_TAIL   = 3'd4,
        S_GAP    = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [3:0]                r_bit;
    logic [15:0]               r_shift;
    logic [12*NUM_SAMPLES-1:0] r_snap;
    logic [3:0]                r_idx;
    logic                      r_cs;
    logic                      r_sclk;
    logic                      r_mosi;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_half_end;
    logic                      w_gap_end;
    logic                      w_timed;
    logic [11:0]               w_sample;

    assign w_half_end = (r_cnt == c_HALF_LAST);
    assign w_gap_end  = (r_cnt == c_GAP_LAST);
    assign w_timed    = (r_state == S_BIT_LO) || (r_state == S_BIT_HI) ||
                        (r_state == S_TAIL)   || (r_state == S_GAP);

    // Sample selector over the snapshot, indexed by the current sample.
    always_comb begin
        w_sample = r_snap[11:0];
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            if (r_idx == 4'(k)) begin
                w_sample = r_snap[12*k +: 12];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start)      w_next_state = S_LOAD;
            S_LOAD:                   w_next_state = S_BIT_LO;
            S_BIT_LO: if (w_half_end) w_next_state = S_BIT_HI;
            S_BIT_HI: if (w_half_end) w_next_state = (r_bit == c_LAST_BIT) ? S_TAIL : S_BIT_LO;
            S_TAIL:   if (w_half_end) w_next_state = S_GAP;
            S_GAP:    if (w_gap_end)  w_next_state = (r_idx == 4'd0) ? S_FIN : S_LOAD;
            S_FIN:                    w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Phase counter: restarts on every state change so a phase always
    // runs its full length and never wraps part-way through.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (w_timed) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and SPI pins
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap  <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_snap <= storage;
                        r_idx  <= c_IDX_FIRST;
                        r_busy <= 1'b1;
                        // CS drops as LOAD is entered so that the LOAD cycle
                        // belongs to the frame (CS low = 1 + 33 half periods).
                        r_cs   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_shift <= {DAC_CFG, w_sample};
                    r_mosi  <= DAC_CFG[3];
                    r_bit   <= '0;
                end
                S_BIT_LO: begin
                    if (w_half_end) begin
                        r_sclk <= 1'b1;
                    end
                end
                S_BIT_HI: begin
                    if (w_half_end) begin
                        // Falling SCLK edge: the only place MOSI advances
                        // inside a frame. Zero fill leaves MOSI low after bit 0.
                        r_sclk  <= 1'b0;
                        r_shift <= {r_shift[14:0], 1'b0};
                        r_mosi  <= r_shift[14];
                        r_bit   <= r_bit + 1'b1;
                    end
                end
                S_TAIL: begin
                    if (w_half_end) begin
                        r_cs <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end && (r_idx != 4'd0)) begin
                        r_idx <= r_idx - 1'b1;
                        r_cs  <= 1'b0;
                    end
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_mosi <= 1'b0;
                end
                default: begin
                    r_cs   <= 1'b1;
                    r_sclk <= 1'b0;
                end
            endcase
        end
    end

    assign CS         = r_cs;
    assign SCLK       = r_sclk;
    assign MOSI       = r_mosi;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sample_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_dac_playback_12bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_playback_12bit
// Description : Directed self-checking bench for dac_playback_12bit with
//               HALF_PER=4, CS_GAP=3, NUM_SAMPLES=10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_playback_12bit;

    localparam int HALF_PER    = 4;
    localparam int NUM_SAMPLES = 10;
    localparam int CS_GAP      = 3;

    logic                      clk   = 1'b0;
    logic                      rst   = 1'b0;
    logic                      start = 1'b0;
    logic [12*NUM_SAMPLES-1:0] storage;
    logic                      CS;
    logic                      SCLK;
    logic                      MOSI;
    logic                      busy;
    logic                      done;
    logic [3:0]                sample_idx;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    // Samples k = 0 .. 9 (k = 9 is the oldest and goes out first).
    logic [11:0] samp [10] = '{12'h0AB, 12'h357, 12'h246, 12'h135, 12'hDEF,
                               12'hABC, 12'h789, 12'h456, 12'h123, 12'hFED};

    dac_playback_12bit #(
        .HALF_PER    (HALF_PER),
        .NUM_SAMPLES (NUM_SAMPLES),
        .CS_GAP      (CS_GAP),
        .DAC_CFG     (4'b0011)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .storage    (storage),
        .CS         (CS),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .busy       (busy),
        .done       (done),
        .sample_idx (sample_idx)
    );

    always #10 clk = ~clk;

    // ------------------------------------------------------------------
    // Pin monitor, sampled on the falling clk edge.
    // ------------------------------------------------------------------
    logic        mon_clr = 1'b0;
    logic        m_sclk_prev = 1'b0;
    logic        m_cs_prev   = 1'b1;
    logic        m_mosi_prev = 1'b0;
    logic [15:0] frame_word  = '0;
    logic [15:0] frames [32];
    int frame_cnt  = 0;
    int rise_cnt   = 0;
    int done_cnt   = 0;
    int mosi_viol  = 0;
    int cs_lo_run  = 0;
    int cs_hi_run  = 0;
    int sclk_hi_run = 0;
    int cs_lo_min  = 99999;
    int cs_lo_max  = 0;
    int sclk_hi_min = 99999;
    int sclk_hi_max = 0;
    int last_cs_hi = 0;

    always @(negedge clk) begin
        if (mon_clr) begin
            frame_word  <= '0;
            frame_cnt   <= 0;
            rise_cnt    <= 0;
            done_cnt    <= 0;
            mosi_viol   <= 0;
            cs_lo_run   <= 0;
            cs_hi_run   <= 0;
            sclk_hi_run <= 0;
            cs_lo_min   <= 99999;
            cs_lo_max   <= 0;
            sclk_hi_min <= 99999;
            sclk_hi_max <= 0;
            last_cs_hi  <= 0;
        end else begin
            if (SCLK && !m_sclk_prev) begin
                rise_cnt   <= rise_cnt + 1;
                frame_word <= {frame_word[14:0], MOSI};
                if (MOSI !== m_mosi_prev) mosi_viol <= mosi_viol + 1;
            end else if (SCLK && m_sclk_prev && (MOSI !== m_mosi_prev)) begin
                mosi_viol <= mosi_viol + 1;
            end
            if (SCLK) begin
                sclk_hi_run <= sclk_hi_run + 1;
            end else if (m_sclk_prev) begin
                sclk_hi_min <= (sclk_hi_run < sclk_hi_min) ? sclk_hi_run : sclk_hi_min;
                sclk_hi_max <= (sclk_hi_run > sclk_hi_max) ? sclk_hi_run : sclk_hi_max;
                sclk_hi_run <= 0;
            end
            if (!CS) begin
                cs_lo_run <= cs_lo_run + 1;
            end else if (!m_cs_prev) begin
                cs_lo_min <= (cs_lo_run < cs_lo_min) ? cs_lo_run : cs_lo_min;
                cs_lo_max <= (cs_lo_run > cs_lo_max) ? cs_lo_run : cs_lo_max;
                cs_lo_run <= 0;
                if (frame_cnt < 32) frames[frame_cnt] <= frame_word;
                frame_cnt  <= frame_cnt + 1;
                frame_word <= '0;
            end
            if (CS) begin
                cs_hi_run <= cs_hi_run + 1;
            end else if (m_cs_prev) begin
                last_cs_hi <= cs_hi_run;
                cs_hi_run  <= 0;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
        m_sclk_prev <= SCLK;
        m_cs_prev   <= CS;
        m_mosi_prev <= MOSI;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    initial begin
        int cyc;
        int rif;
        int r0;
        logic prev_s;

        for (int k = 0; k < NUM_SAMPLES; k++) storage[12*k +: 12] = samp[k];

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_CS",   32'(CS),         32'd1);
        check("rst_SCLK", 32'(SCLK),       32'd0);
        check("rst_MOSI", 32'(MOSI),       32'd0);
        check("rst_busy", 32'(busy),       32'd0);
        check("rst_done", 32'(done),       32'd0);
        check("rst_idx",  32'(sample_idx), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        clear_monitor();

        // ---------------- single buffer + snapshot + busy start ----------------
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);               // accept edge
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", 32'(busy),       32'd1);
        check("accept_idx",  32'(sample_idx), 32'd9);
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 186) storage = '1;      // inside frame 2
            if (cyc == 594) start = 1'b1;      // inside frame 5, busy
            if (cyc == 595) start = 1'b0;
            if (done) break;
        end
        check("done_latency", 32'(cyc), 32'd1361);
        check("done_busy_low", 32'(busy), 32'd0);
        repeat (60) @(negedge clk);
        #1;
        check("frame_count", 32'(frame_cnt), 32'd10);
        check("rise_count",  32'(rise_cnt),  32'd160);
        check("done_pulses", 32'(done_cnt),  32'd1);
        check("cs_low_min",  32'(cs_lo_min), 32'd133);
        check("cs_low_max",  32'(cs_lo_max), 32'd133);
        check("sclk_hi_min", 32'(sclk_hi_min), 32'd4);
        check("sclk_hi_max", 32'(sclk_hi_max), 32'd4);
        check("mosi_stable", 32'(mosi_viol), 32'd0);
        check("idle_busy",   32'(busy),      32'd0);
        check("frame_first", 32'(frames[0]), 32'h3FED);
        check("frame_last",  32'(frames[9]), 32'h30AB);
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            check($sformatf("frame_%0d", i), 32'(frames[i]), 32'({4'h3, samp[9-i]}));
        end

        // ---------------- back-to-back with start held ----------------
        for (int k = 0; k < NUM_SAMPLES; k++) storage[12*k +: 12] = samp[k];
        clear_monitor();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) break;
        end
        check("b2b_latency", 32'(cyc),  32'd1361);
        check("b2b_done",    32'(done), 32'd1);
        check("b2b_busy_lo", 32'(busy), 32'd0);
        #1;
        check("b2b_frames",  32'(frame_cnt), 32'd10);
        @(negedge clk);
        start = 1'b0;
        check("b2b_restart_busy", 32'(busy),       32'd1);
        check("b2b_restart_idx",  32'(sample_idx), 32'd9);
        check("b2b_restart_CS",   32'(CS),         32'd0);
        #1;
        chk_cnt++;
        assert (last_cs_hi >= CS_GAP + 2) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL b2b_cs_gap: observed %0d expected >= %0d", last_cs_hi, CS_GAP + 2);
        end

        // ---------------- reset in the middle of bit 7 ----------------
        rif = 0;
        prev_s = SCLK;
        cyc = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!CS && SCLK && !prev_s) rif++;
            if (CS) rif = 0;
            prev_s = SCLK;
            if (rif == 7) break;
        end
        check("bit7_reached", 32'(rif), 32'd7);
        #1;
        r0 = rise_cnt;
        rst = 1'b0;
        #1;
        check("midrst_CS",   32'(CS),   32'd1);
        check("midrst_SCLK", 32'(SCLK), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("postrst_no_sclk", 32'(rise_cnt), 32'(r0));
        check("postrst_CS",      32'(CS),       32'd1);
        check("postrst_busy",    32'(busy),     32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
